// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding.
// Emits one registered scancode event (or error pulse) per frame.
module ps2_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 17600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    output logic       strobe,
    output logic [7:0] code,
    output logic       pressed,
    output logic       extended,
    output logic       error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic          fclk_q, fclk_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          ext_f_q, ext_f_d;
    logic          rel_f_q, rel_f_d;
    logic [7:0]    code_q, code_d;
    logic          pressed_q, pressed_d;
    logic          ext_q, ext_d;
    logic          strobe_q, strobe_d;
    logic          error_q, error_d;
    logic          sample;
    logic          din;

    assign din = sync2_q[1];

    always_comb begin
        state_d   = state_q;
        sync1_d   = sync1_q;
        sync2_d   = sync2_q;
        fclk_d    = fclk_q;
        fcnt_d    = fcnt_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        par_d     = par_q;
        tout_d    = tout_q;
        ext_f_d   = ext_f_q;
        rel_f_d   = rel_f_q;
        code_d    = code_q;
        pressed_d = pressed_q;
        ext_d     = ext_q;
        strobe_d  = 1'b0;
        error_d   = 1'b0;
        sample    = 1'b0;

        if (ce) begin
            sync1_d = ps2;
            sync2_d = sync1_q;

            // Accept a new clock level only on the FILTER-th differing sample
            if (sync2_q[0] == fclk_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == 4'(FILTER - 1)) begin
                fcnt_d = '0;
                fclk_d = sync2_q[0];
                sample = fclk_q;
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end

            if (sample) begin
                tout_d = '0;
                unique case (state_q)
                    IDLE: begin
                        if (!din) begin
                            state_d  = DATA;
                            bitcnt_d = '0;
                        end
                    end
                    DATA: begin
                        shift_d  = {din, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = PARITY;
                    end
                    PARITY: begin
                        par_d   = din;
                        state_d = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        if (din && (^{shift_q, par_q})) begin
                            if (shift_q == 8'hE0) begin
                                ext_f_d = 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                rel_f_d = 1'b1;
                            end else begin
                                code_d    = shift_q;
                                pressed_d = ~rel_f_q;
                                ext_d     = ext_f_q;
                                strobe_d  = 1'b1;
                                ext_f_d   = 1'b0;
                                rel_f_d   = 1'b0;
                            end
                        end else begin
                            error_d = 1'b1;
                            ext_f_d = 1'b0;
                            rel_f_d = 1'b0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (tout_q == TW'(TIMEOUT - 1)) begin
                    tout_d  = TW'(TIMEOUT);
                    state_d = IDLE;
                    error_d = 1'b1;
                    ext_f_d = 1'b0;
                    rel_f_d = 1'b0;
                end else if (tout_q != TW'(TIMEOUT)) begin
                    tout_d = tout_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            fclk_q    <= 1'b1;
            fcnt_q    <= '0;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            par_q     <= 1'b0;
            tout_q    <= '0;
            ext_f_q   <= 1'b0;
            rel_f_q   <= 1'b0;
            code_q    <= '0;
            pressed_q <= 1'b0;
            ext_q     <= 1'b0;
            strobe_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            fclk_q    <= fclk_d;
            fcnt_q    <= fcnt_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            par_q     <= par_d;
            tout_q    <= tout_d;
            ext_f_q   <= ext_f_d;
            rel_f_q   <= rel_f_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
            ext_q     <= ext_d;
            strobe_q  <= strobe_d;
            error_q   <= error_d;
        end
    end

    assign strobe   = strobe_q;
    assign code     = code_q;
    assign pressed  = pressed_q;
    assign extended = ext_q;
    assign error    = error_q;

endmodule
